// File: rtl/axi_stream_strip_header_if.sv
// ---------------------------------------------------------------------------
// axi_stream_strip_header_if
//   AXI-Stream style channel bundle used for the packet input, the stripped
//   header output and the re-aligned payload output of axi_stream_strip_header.
//
//   Signals
//     valid  source -> sink   beat valid
//     data   source -> sink   DATA_WD bits, byte DATA_BYTE_WD-1 (MSB) first
//     keep   source -> sink   byte enables, MSB-contiguous
//     last   source -> sink   last beat of packet (tied low on the header channel)
//     ready  sink -> source   beat transfers when valid & ready
//
//   Modports: master (drives valid/data/keep/last), slave (drives ready).
// ---------------------------------------------------------------------------
interface axi_stream_strip_header_if #(
  parameter int DATA_WD = 32
) ();
  localparam int DATA_BYTE_WD = DATA_WD / 8;

  logic                    valid;
  logic [DATA_WD-1:0]      data;
  logic [DATA_BYTE_WD-1:0] keep;
  logic                    last;
  logic                    ready;

  modport master (output valid, output data, output keep, output last, input  ready);
  modport slave  (input  valid, input  data, input  keep, input  last, output ready);
endinterface

// File: rtl/axi_stream_strip_header.sv
// ---------------------------------------------------------------------------
// axi_stream_strip_header
//   Removes an n-byte header (n = i_byte_strip_cnt + 1, 1..DATA_BYTE_WD) from
//   the front of every AXI-Stream packet. The header is presented LSB-aligned
//   on its own channel; the remaining payload is re-packed into full
//   MSB-first beats. One beat per cycle, all outputs registered, one cycle
//   latency from an accepted input beat.
//
//   Ports
//     clk               clock
//     rst_n             asynchronous, active-low reset
//     i_axis            (slave)  incoming packet beats
//     i_byte_strip_cnt  header length minus one, sampled on the first beat
//     o_hdr             (master) header bytes, LSB-aligned; last tied low
//     o_axis            (master) re-aligned payload
//     o_hdr_short       only when AXIS_STRIP_ERR_CHECK_EN is defined: one-cycle
//                       pulse, registered with the header, when a packet ends on
//                       its first beat with fewer than n bytes
//
//   Build option
//     AXIS_STRIP_ERR_CHECK_EN  adds the o_hdr_short truncated-header flag.
//     Without it a truncated header is still forwarded with reduced keep.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_HDR   | waiting for the first beat of a packet (header beat)
//   S_BODY  | header taken; merging residue with each following beat
//   S_FLUSH | input finished; emit remaining residue bytes as the last beat
// ---------------------------------------------------------------------------
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  axi_stream_strip_header_if.slave        i_axis,
  input  logic [BYTE_CNT_WD-1:0]          i_byte_strip_cnt,
  axi_stream_strip_header_if.master       o_hdr,
  axi_stream_strip_header_if.master       o_axis
`ifdef AXIS_STRIP_ERR_CHECK_EN
  ,
  output logic                            o_hdr_short
`endif
);

  // Byte counts run 0..DATA_BYTE_WD inclusive, so one bit wider than the strip count.
  localparam int CW = $clog2(DATA_BYTE_WD + 1);

  typedef enum logic [1:0] {
    S_HDR   = 2'd0,
    S_BODY  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_n;
  logic [CW-1:0]           r_res_cnt;
  logic [DATA_WD-1:0]      r_res;

  logic                    r_hdr_valid;
  logic [DATA_WD-1:0]      r_hdr_data;
  logic [DATA_BYTE_WD-1:0] r_hdr_keep;

  logic                    r_out_valid;
  logic [DATA_WD-1:0]      r_out_data;
  logic [DATA_BYTE_WD-1:0] r_out_keep;
  logic                    r_out_last;

`ifdef AXIS_STRIP_ERR_CHECK_EN
  logic                    r_hdr_short;
`endif

  logic [CW-1:0]           w_n_first;
  logic [CW-1:0]           w_n;
  logic [CW-1:0]           w_k;
  logic [CW-1:0]           w_lo_bytes;
  logic [DATA_WD-1:0]      w_top;
  logic [DATA_WD-1:0]      w_res_next;
  logic [DATA_BYTE_WD-1:0] w_hdr_keep;
  logic                    w_ready_in;
  logic                    w_in_fire;
  logic                    w_out_free;
  logic                    w_hdr_free;
  logic                    w_k_gt_n;

  // Keep mask with the c most-significant byte lanes set.
  function automatic logic [DATA_BYTE_WD-1:0] msb_ones(input logic [CW-1:0] c);
    return ~({DATA_BYTE_WD{1'b1}} >> c);
  endfunction

  assign w_n_first = CW'(i_byte_strip_cnt) + CW'(1);

  // The strip length is live from the input on the header beat and held afterwards.
  assign w_n        = (r_state == S_HDR) ? w_n_first : r_n;
  assign w_lo_bytes = CW'(DATA_BYTE_WD) - w_n;

  always_comb begin
    w_k = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      w_k = w_k + CW'(i_axis.keep[i]);
    end
  end

  // Top n bytes shifted down to the LSB end: header on the first beat, the
  // tail of the merged output word on body beats.
  assign w_top      = i_axis.data >> {w_lo_bytes, 3'b000};
  // Low DATA_BYTE_WD-n bytes kept MSB-aligned; empty (all zero) when n = DATA_BYTE_WD.
  assign w_res_next = i_axis.data << {w_n, 3'b000};
  assign w_hdr_keep = i_axis.keep >> w_lo_bytes;
  assign w_k_gt_n   = (w_k > w_n);

  assign w_out_free = !r_out_valid || o_axis.ready;
  assign w_hdr_free = !r_hdr_valid || o_hdr.ready;

  always_comb begin
    w_ready_in = 1'b0;
    case (r_state)
      S_HDR:   w_ready_in = w_hdr_free;
      S_BODY:  w_ready_in = w_out_free;
      S_FLUSH: w_ready_in = 1'b0;
      default: w_ready_in = 1'b0;
    endcase
  end

  assign w_in_fire = i_axis.valid && w_ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HDR;
      r_n         <= '0;
      r_res_cnt   <= '0;
      r_res       <= '0;
      r_hdr_valid <= 1'b0;
      r_hdr_data  <= '0;
      r_hdr_keep  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
`ifdef AXIS_STRIP_ERR_CHECK_EN
      r_hdr_short <= 1'b0;
`endif
    end else begin
      // Consumed beats retire unless reloaded below in the same cycle.
      if (r_hdr_valid && o_hdr.ready) r_hdr_valid <= 1'b0;
      if (r_out_valid && o_axis.ready) r_out_valid <= 1'b0;
`ifdef AXIS_STRIP_ERR_CHECK_EN
      r_hdr_short <= 1'b0;
`endif

      case (r_state)
        S_HDR: begin
          if (w_in_fire) begin
            r_n         <= w_n;
            r_res       <= w_res_next;
            r_hdr_valid <= 1'b1;
            r_hdr_data  <= w_top;
            r_hdr_keep  <= w_hdr_keep;
`ifdef AXIS_STRIP_ERR_CHECK_EN
            r_hdr_short <= i_axis.last && (w_k < w_n);
`endif
            if (!i_axis.last) begin
              r_state <= S_BODY;
            end else if (w_k_gt_n) begin
              // Single-beat packet that still carries payload bytes after the header.
              r_res_cnt <= w_k - w_n;
              r_state   <= S_FLUSH;
            end
          end
        end

        S_BODY: begin
          if (w_in_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_res | w_top;
            r_res       <= w_res_next;
            if (!i_axis.last) begin
              r_out_keep <= '1;
              r_out_last <= 1'b0;
            end else if (!w_k_gt_n) begin
              // Residue plus the k bytes of the final beat fit in this output beat.
              r_out_keep <= msb_ones(w_lo_bytes + w_k);
              r_out_last <= 1'b1;
              r_state    <= S_HDR;
            end else begin
              r_out_keep <= '1;
              r_out_last <= 1'b0;
              r_res_cnt  <= w_k - w_n;
              r_state    <= S_FLUSH;
            end
          end
        end

        S_FLUSH: begin
          if (w_out_free) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_res;
            r_out_keep  <= msb_ones(r_res_cnt);
            r_out_last  <= 1'b1;
            r_state     <= S_HDR;
          end
        end

        default: r_state <= S_HDR;
      endcase
    end
  end

  assign i_axis.ready = w_ready_in;

  assign o_hdr.valid  = r_hdr_valid;
  assign o_hdr.data   = r_hdr_data;
  assign o_hdr.keep   = r_hdr_keep;
  assign o_hdr.last   = 1'b0;

  assign o_axis.valid = r_out_valid;
  assign o_axis.data  = r_out_data;
  assign o_axis.keep  = r_out_keep;
  assign o_axis.last  = r_out_last;

`ifdef AXIS_STRIP_ERR_CHECK_EN
  assign o_hdr_short  = r_hdr_short;
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Bench for axi_stream_strip_header: directed table of packets, hand-written
// stall/reset sequences, then randomized packets against a byte-list model.
module tb_axi_stream_strip_header;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cnt = 2'd0;

  always #5 clk = ~clk;

  axi_stream_strip_header_if #(.DATA_WD(32)) in_if ();
  axi_stream_strip_header_if #(.DATA_WD(32)) hdr_if ();
  axi_stream_strip_header_if #(.DATA_WD(32)) out_if ();

`ifdef AXIS_STRIP_ERR_CHECK_EN
  logic hdr_short;
`endif

  axi_stream_strip_header #(.DATA_WD(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_axis           (in_if),
    .i_byte_strip_cnt (cnt),
    .o_hdr            (hdr_if),
    .o_axis           (out_if)
`ifdef AXIS_STRIP_ERR_CHECK_EN
    ,
    .o_hdr_short      (hdr_short)
`endif
  );

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  cnt;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  typedef struct {
    logic [1:0]        cnt;
    int                nb;
    logic [2:0][31:0]  d;
    logic [2:0][3:0]   k;
    logic [31:0]       hd;
    logic [3:0]        hk;
    int                no;
    logic [2:0][31:0]  od;
    logic [2:0][3:0]   ok;
    int                shrt;
  } dir_t;

  beat_t stim_q[$];
  exp_t  exp_hdr_q[$];
  exp_t  exp_out_q[$];
  int    exp_short = 0;
  int    seen_short = 0;
  dir_t  tbl[6];

  function automatic logic [31:0] bmask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    in_if.valid = 1'b0;
    in_if.data  = '0;
    in_if.keep  = '0;
    in_if.last  = 1'b0;
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] c);
    in_if.valid = 1'b1;
    in_if.data  = d;
    in_if.keep  = k;
    in_if.last  = l;
    cnt         = c;
  endtask

  // Drives stim_q and checks both output channels until everything is consumed.
  task automatic run(input bit rnd, input int budget);
    int   cyc = 0;
    int   extra = 0;
    bit   pres = 1'b0;
    exp_t e;
    while ((stim_q.size() != 0 || exp_hdr_q.size() != 0 || exp_out_q.size() != 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (!pres) begin
        if (stim_q.size() != 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
          drive(stim_q[0].data, stim_q[0].keep, stim_q[0].last, stim_q[0].cnt);
          pres = 1'b1;
        end else begin
          idle_in();
        end
      end
      hdr_if.ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      out_if.ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (pres && in_if.ready) begin
        void'(stim_q.pop_front());
        pres = 1'b0;
      end
      if (hdr_if.valid && hdr_if.ready) begin
        if (exp_hdr_q.size() == 0) chk("hdr_unexpected", 64'(hdr_if.keep), 64'hFFFF);
        else begin
          e = exp_hdr_q.pop_front();
          chk("hdr_keep", hdr_if.keep, e.keep);
          chk("hdr_data", hdr_if.data & bmask(e.keep), e.data & bmask(e.keep));
        end
      end
      if (out_if.valid && out_if.ready) begin
        if (out_if.keep == 4'h0) chk("out_zero_keep", out_if.keep, 4'hF);
        if (exp_out_q.size() == 0) chk("out_unexpected", 64'(out_if.keep), 64'hFFFF);
        else begin
          e = exp_out_q.pop_front();
          chk("out_keep", out_if.keep, e.keep);
          chk("out_last", out_if.last, e.last);
          chk("out_data", out_if.data & bmask(e.keep), e.data & bmask(e.keep));
        end
      end
`ifdef AXIS_STRIP_ERR_CHECK_EN
      if (hdr_short) seen_short++;
`endif
    end
    chk("run_leftover", stim_q.size() + exp_hdr_q.size() + exp_out_q.size(), 0);
    idle_in();
    hdr_if.ready = 1'b1;
    out_if.ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      extra += int'(hdr_if.valid) + int'(out_if.valid);
`ifdef AXIS_STRIP_ERR_CHECK_EN
      if (hdr_short) seen_short++;
`endif
    end
    chk("extra_beats", extra, 0);
  endtask

  task automatic apply_dir(input int i);
    beat_t b;
    exp_t  e;
    for (int j = 0; j < tbl[i].nb; j++) begin
      b.data = tbl[i].d[j];
      b.keep = tbl[i].k[j];
      b.last = (j == tbl[i].nb - 1);
      b.cnt  = tbl[i].cnt;
      stim_q.push_back(b);
    end
    e.data = tbl[i].hd;
    e.keep = tbl[i].hk;
    e.last = 1'b0;
    exp_hdr_q.push_back(e);
    for (int j = 0; j < tbl[i].no; j++) begin
      e.data = tbl[i].od[j];
      e.keep = tbl[i].ok[j];
      e.last = (j == tbl[i].no - 1);
      exp_out_q.push_back(e);
    end
    exp_short += tbl[i].shrt;
    run(1'b0, 200);
  endtask

  // Model: a packet is a list of L bytes; header = first n bytes, payload = rest
  // packed four to a beat.
  task automatic push_rand_packet();
    int          n = $urandom_range(1, 4);
    int          len = $urandom_range(1, 14);
    logic [7:0]  bq[$];
    beat_t       b;
    exp_t        e;
    for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
    for (int s = 0; s < len; s += B) begin
      b.data = $urandom;
      b.keep = '0;
      for (int j = 0; j < B; j++) begin
        if (s + j < len) begin
          b.data[31-8*j -: 8] = bq[s+j];
          b.keep[3-j]         = 1'b1;
        end
      end
      b.last = (s + B >= len);
      b.cnt  = 2'(n - 1);
      stim_q.push_back(b);
    end
    e.data = '0;
    e.keep = '0;
    e.last = 1'b0;
    for (int j = 0; j < n; j++) begin
      if (j < len) begin
        e.data[8*(n-1-j) +: 8] = bq[j];
        e.keep[n-1-j]          = 1'b1;
      end
    end
    exp_hdr_q.push_back(e);
    if (len < n) exp_short++;
    for (int p = n; p < len; p += B) begin
      e.data = '0;
      e.keep = '0;
      for (int j = 0; j < B; j++) begin
        if (p + j < len) begin
          e.data[31-8*j -: 8] = bq[p+j];
          e.keep[3-j]         = 1'b1;
        end
      end
      e.last = (p + B >= len);
      exp_out_q.push_back(e);
    end
  endtask

  initial begin
    tbl[0] = '{2'd2, 3, {32'h090A0B0C, 32'h05060708, 32'h01020304}, {4'hC, 4'hF, 4'hF},
               32'h00010203, 4'h7, 2, {32'h0, 32'h08090A00, 32'h04050607}, {4'h0, 4'hE, 4'hF}, 0};
    tbl[1] = '{2'd3, 2, {32'h0, 32'h05060708, 32'h01020304}, {4'h0, 4'hF, 4'hF},
               32'h01020304, 4'hF, 1, {32'h0, 32'h0, 32'h05060708}, {4'h0, 4'h0, 4'hF}, 0};
    tbl[2] = '{2'd0, 2, {32'h0, 32'h05060708, 32'h01020304}, {4'h0, 4'hF, 4'hF},
               32'h00000001, 4'h1, 2, {32'h0, 32'h06070800, 32'h02030405}, {4'h0, 4'hE, 4'hF}, 0};
    tbl[3] = '{2'd2, 1, {32'h0, 32'h0, 32'h01020304}, {4'h0, 4'h0, 4'hC},
               32'h00010200, 4'h6, 0, {32'h0, 32'h0, 32'h0}, {4'h0, 4'h0, 4'h0}, 1};
    tbl[4] = '{2'd3, 2, {32'h0, 32'h55667788, 32'h11223344}, {4'h0, 4'hE, 4'hF},
               32'h11223344, 4'hF, 1, {32'h0, 32'h0, 32'h55667700}, {4'h0, 4'h0, 4'hE}, 0};
    tbl[5] = '{2'd1, 1, {32'h0, 32'h0, 32'h01020304}, {4'h0, 4'h0, 4'hF},
               32'h00000102, 4'h3, 1, {32'h0, 32'h0, 32'h03040000}, {4'h0, 4'h0, 4'hC}, 0};

    idle_in();
    hdr_if.ready = 1'b1;
    out_if.ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid_hdr", hdr_if.valid, 1'b0);
    chk("rst_valid_out", out_if.valid, 1'b0);
    chk("rst_last_out", out_if.last, 1'b0);
    chk("rst_data_out", out_if.data, 32'h0);
    chk("rst_keep_hdr", hdr_if.keep, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_in", in_if.ready, 1'b1);

    for (int i = 0; i < 6; i++) apply_dir(i);

    // Payload back-pressure mid-packet.
    @(negedge clk);
    out_if.ready = 1'b0;
    hdr_if.ready = 1'b1;
    drive(32'h01020304, 4'hF, 1'b0, 2'd2);
    #1 chk("bp_ready_first", in_if.ready, 1'b1);
    @(negedge clk);
    drive(32'h05060708, 4'hF, 1'b0, 2'd2);
    #1;
    chk("bp_hdr_data", hdr_if.data & 32'h00FFFFFF, 32'h00010203);
    chk("bp_ready_body", in_if.ready, 1'b1);
    @(negedge clk);
    drive(32'h090A0B0C, 4'hC, 1'b1, 2'd2);
    #1;
    chk("bp_out_valid", out_if.valid, 1'b1);
    chk("bp_ready_low", in_if.ready, 1'b0);
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("bp_ready_stall", in_if.ready, 1'b0);
      chk("bp_out_held", out_if.data, 32'h04050607);
    end
    @(negedge clk);
    out_if.ready = 1'b1;
    #1 chk("bp_ready_release", in_if.ready, 1'b1);
    @(negedge clk);
    idle_in();
    #1;
    chk("bp_tail_data", out_if.data & 32'hFFFFFF00, 32'h08090A00);
    chk("bp_tail_keep", out_if.keep, 4'hE);
    chk("bp_tail_last", out_if.last, 1'b1);
    @(negedge clk);
    #1 chk("bp_drained", out_if.valid, 1'b0);

    // Header back-pressure blocks the next packet's first beat.
    @(negedge clk);
    hdr_if.ready = 1'b0;
    drive(32'h01020304, 4'hF, 1'b1, 2'd3);
    @(negedge clk);
    drive(32'hAABBCCDD, 4'hF, 1'b1, 2'd3);
    #1;
    chk("hs_ready_low", in_if.ready, 1'b0);
    chk("hs_hdr_a", hdr_if.data, 32'h01020304);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("hs_ready_stall", in_if.ready, 1'b0);
      chk("hs_no_payload", out_if.valid, 1'b0);
    end
    @(negedge clk);
    hdr_if.ready = 1'b1;
    #1 chk("hs_ready_release", in_if.ready, 1'b1);
    @(negedge clk);
    idle_in();
    #1;
    chk("hs_hdr_b_valid", hdr_if.valid, 1'b1);
    chk("hs_hdr_b", hdr_if.data, 32'hAABBCCDD);
    @(negedge clk);

    // Asynchronous reset in the middle of a packet.
    drive(32'h01020304, 4'hF, 1'b0, 2'd2);
    @(negedge clk);
    drive(32'h05060708, 4'hF, 1'b0, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_hdr", hdr_if.valid, 1'b0);
    chk("mid_rst_valid_out", out_if.valid, 1'b0);
    @(negedge clk);
    idle_in();
    rst_n = 1'b1;
    apply_dir(0);

    repeat (150) push_rand_packet();
    run(1'b1, 20000);

`ifdef AXIS_STRIP_ERR_CHECK_EN
    chk("hdr_short_count", seen_short, exp_short);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
